mmu_arbiter: RTL

Two-port arbiter and sequencer in front of the `mmu`, sharing its single request interface between the instruction-fetch port (IF) and the load/store port (LS). It grants one request at a time with round-robin priority and pulses the MMU enable for exactly one cycle. It holds address, data and width stable until `mem_ready`, then returns the read data, or an error on timeout, to the owning requester. It sits between the core's fetch/memory stages and the `mmu`.

---
 rtl/mmu_arbiter_if.sv | 54 +++++
 rtl/mmu_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu_arbiter_if.sv
// Shared request/response bundle between the fetch and load/store ports, the arbiter and the MMU.
// The arbiter connects through the slave modport; the core/MMU side uses master.
interface mmu_arbiter_if;
  logic        if_req;
  logic [31:0] if_address;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic        ls_we;
  logic        ls_signed;
  logic [1:0]  ls_width;
  logic [31:0] ls_address;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic        mmu_write_enable;
  logic        mmu_read_enable;
  logic        mmu_signed_read;
  logic [1:0]  mmu_data_width;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;
  logic        mmu_ready;

  logic        busy;

  modport slave (
    input  if_req, if_address,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_we, ls_signed, ls_width, ls_address, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mmu_write_enable, mmu_read_enable, mmu_signed_read, mmu_data_width,
    output mmu_address, mmu_data_in,
    input  mmu_data_out, mmu_ready,
    output busy
  );

  modport master (
    output if_req, if_address,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_we, ls_signed, ls_width, ls_address, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mmu_write_enable, mmu_read_enable, mmu_signed_read, mmu_data_width,
    input  mmu_address, mmu_data_in,
    output mmu_data_out, mmu_ready,
    input  busy
  );
endinterface

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter/sequencer sharing one MMU request port between fetch (IF) and load/store (LS).
// Grant is combinational in IDLE; enable pulses one cycle; response or timeout error returns to the owner.
module mmu_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mmu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic {PORT_IF, PORT_LS} port_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state, state_nxt;
  port_e       owner, owner_nxt;
  port_e       last_grant, last_grant_nxt;
  logic [7:0]  cnt, cnt_nxt;

  logic        we_q, we_nxt;
  logic        sgn_q, sgn_nxt;
  logic [1:0]  width_q, width_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        rd_en_q, rd_en_nxt;
  logic        wr_en_q, wr_en_nxt;

  logic        if_rvalid_q, if_rvalid_nxt;
  logic [31:0] if_rdata_q, if_rdata_nxt;
  logic        if_err_q, if_err_nxt;
  logic        ls_rvalid_q, ls_rvalid_nxt;
  logic [31:0] ls_rdata_q, ls_rdata_nxt;
  logic        ls_err_q, ls_err_nxt;
  logic        busy_q, busy_nxt;

  logic        grant_if, grant_ls;
  logic        resp_take;
  logic [31:0] resp_data;
  logic        resp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner       <= PORT_IF;
      last_grant  <= PORT_LS;
      cnt         <= '0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      width_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_grant  <= last_grant_nxt;
      cnt         <= cnt_nxt;
      we_q        <= we_nxt;
      sgn_q       <= sgn_nxt;
      width_q     <= width_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      rd_en_q     <= rd_en_nxt;
      wr_en_q     <= wr_en_nxt;
      if_rvalid_q <= if_rvalid_nxt;
      if_rdata_q  <= if_rdata_nxt;
      if_err_q    <= if_err_nxt;
      ls_rvalid_q <= ls_rvalid_nxt;
      ls_rdata_q  <= ls_rdata_nxt;
      ls_err_q    <= ls_err_nxt;
      busy_q      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    we_nxt         = we_q;
    sgn_nxt        = sgn_q;
    width_nxt      = width_q;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    rd_en_nxt      = 1'b0;
    wr_en_nxt      = 1'b0;
    if_rvalid_nxt  = 1'b0;
    if_rdata_nxt   = if_rdata_q;
    if_err_nxt     = if_err_q;
    ls_rvalid_nxt  = 1'b0;
    ls_rdata_nxt   = ls_rdata_q;
    ls_err_nxt     = ls_err_q;
    grant_if       = 1'b0;
    grant_ls       = 1'b0;
    resp_take      = 1'b0;
    resp_data      = '0;
    resp_err       = 1'b0;

    case (state)
      ST_IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (!reset) begin
          if (bus.if_req && (!bus.ls_req || last_grant == PORT_LS)) begin
            grant_if = 1'b1;
          end else if (bus.ls_req) begin
            grant_ls = 1'b1;
          end
        end
        if (grant_if) begin
          owner_nxt = PORT_IF;
          we_nxt    = 1'b0;
          sgn_nxt   = 1'b0;
          width_nxt = 2'd3;
          addr_nxt  = bus.if_address;
          wdata_nxt = '0;
        end
        if (grant_ls) begin
          owner_nxt = PORT_LS;
          we_nxt    = bus.ls_we;
          sgn_nxt   = bus.ls_signed;
          width_nxt = bus.ls_width;
          addr_nxt  = bus.ls_address;
          wdata_nxt = bus.ls_wdata;
        end
        if (grant_if || grant_ls) begin
          last_grant_nxt = owner_nxt;
          rd_en_nxt      = !we_nxt;
          wr_en_nxt      = we_nxt;
          state_nxt      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mmu_ready) begin
          resp_take = 1'b1;
          resp_data = we_q ? 32'd0 : bus.mmu_data_out;
          resp_err  = 1'b0;
        end else if ((cnt + 8'd1) == TIMEOUT_CNT) begin
          resp_take = 1'b1;
          resp_data = '0;
          resp_err  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Only the owner's response registers move; the other port keeps its last result.
    if (resp_take) begin
      state_nxt = ST_RESP;
      if (owner == PORT_IF) begin
        if_rvalid_nxt = 1'b1;
        if_rdata_nxt  = resp_data;
        if_err_nxt    = resp_err;
      end else begin
        ls_rvalid_nxt = 1'b1;
        ls_rdata_nxt  = resp_data;
        ls_err_nxt    = resp_err;
      end
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign bus.if_gnt           = grant_if;
  assign bus.ls_gnt           = grant_ls;
  assign bus.if_rvalid        = if_rvalid_q;
  assign bus.if_rdata         = if_rdata_q;
  assign bus.if_err           = if_err_q;
  assign bus.ls_rvalid        = ls_rvalid_q;
  assign bus.ls_rdata         = ls_rdata_q;
  assign bus.ls_err           = ls_err_q;
  assign bus.mmu_read_enable  = rd_en_q;
  assign bus.mmu_write_enable = wr_en_q;
  assign bus.mmu_signed_read  = sgn_q;
  assign bus.mmu_data_width   = width_q;
  assign bus.mmu_address      = addr_q;
  assign bus.mmu_data_in      = wdata_q;
  assign bus.busy             = busy_q;

  a_one_grant: assert property (@(posedge clk) disable iff (reset) !(grant_if && grant_ls));
  a_one_enable: assert property (@(posedge clk) disable iff (reset) !(rd_en_q && wr_en_q));
  a_one_rvalid: assert property (@(posedge clk) disable iff (reset) !(if_rvalid_q && ls_rvalid_q));
  a_enable_in_issue: assert property (@(posedge clk) disable iff (reset)
    (rd_en_q || wr_en_q) |-> (state == ST_ISSUE));

endmodule
